// File: rtl/truth_table_probe.sv
// ============================================================================
// Module      : truth_table_probe
// Description : Characterizes a 3-input combinational circuit. Steps the
//               stimulus vector 000..111, holds each vector SETTLE_CYCLES+1
//               cycles, samples the response and assembles an 8-bit truth
//               table ID. The response to vector 000 lands in the MSB.
//               Optional macro TRUTH_TABLE_PROBE_STABILITY_CHECK_EN enables
//               a per-vector output stability check reported on glitch.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  input  logic [7:0] expect_id,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_id,
  output logic       match,
  output logic       glitch
);

  // A settle time of zero is promoted to one cycle.
  localparam int unsigned C_SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0]  C_SETTLE_LAST = 8'(C_SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] k_q;      // vector index within the run
  logic [7:0] cnt_q;    // settle counter inside APPLY
  logic [7:0] run_q;    // truth table under construction
  logic [2:0] vec_q;    // registered stimulus vector
  logic       busy_q;
  logic       done_q;
  logic [7:0] table_q;
  logic       match_q;

`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
  logic       last_q;   // dut_out seen in the last APPLY cycle of the vector
  logic       glitch_q;
`endif

  // Run sequencer: steps vectors, captures responses, publishes the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      cnt_q    <= 8'd0;
      run_q    <= 8'd0;
      vec_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= 8'd0;
      match_q  <= 1'b0;
`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
      last_q   <= 1'b0;
      glitch_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= APPLY;
            k_q      <= 3'd0;
            cnt_q    <= 8'd0;
            run_q    <= 8'd0;
            vec_q    <= 3'd0;
            busy_q   <= 1'b1;
`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
            glitch_q <= 1'b0;
`endif
          end
        end
        APPLY: begin
          if (cnt_q == C_SETTLE_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= SAMPLE;
`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
            last_q  <= dut_out;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SAMPLE: begin
          // Shifting in order 000..111 leaves vector k at bit 7-k.
          run_q <= {run_q[6:0], dut_out};
`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
          if (dut_out != last_q) begin
            glitch_q <= 1'b1;
          end
`endif
          if (k_q == 3'd7) begin
            state_q <= FINISH;
            busy_q  <= 1'b0;
            vec_q   <= 3'd0;
          end else begin
            k_q     <= k_q + 3'd1;
            vec_q   <= k_q + 3'd1;
            state_q <= APPLY;
          end
        end
        FINISH: begin
          table_q <= run_q;
          match_q <= (run_q == expect_id);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {in1, in2, in3} = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign table_id        = table_q;
  assign match           = match_q;

`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
  assign glitch = glitch_q;
`else
  assign glitch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_truth_table_probe.sv
// ============================================================================
// Module      : tb_truth_table_probe
// Description : Randomized self-checking bench for truth_table_probe. Three
//               instances (SETTLE_CYCLES = 4, 1, 0) each drive their own
//               table-driven circuit model; expected outputs are derived from
//               cycle arithmetic relative to the edge that accepts start.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_truth_table_probe;

`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
  localparam bit C_GLITCH_EN = 1'b1;
`else
  localparam bit C_GLITCH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_m, start_s;
  logic [7:0] expect_id;
  logic [7:0] cut_tbl;
  logic       flip;

  logic       m_in1, m_in2, m_in3, busy_m, done_m, match_m, glitch_m, dut_out_m;
  logic [7:0] table_m;
  logic       a_in1, a_in2, a_in3, busy_a, done_a, match_a, glitch_a, dut_out_a;
  logic [7:0] table_a;
  logic       z_in1, z_in2, z_in3, busy_z, done_z, match_z, glitch_z, dut_out_z;
  logic [7:0] table_z;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_id_m, ref_id_s;
  logic       ref_match_m, ref_match_s;

  // Circuit-under-test models: response to vector v is cut_tbl[7-v].
  assign dut_out_m = cut_tbl[3'd7 - {m_in1, m_in2, m_in3}] ^ flip;
  assign dut_out_a = cut_tbl[3'd7 - {a_in1, a_in2, a_in3}];
  assign dut_out_z = cut_tbl[3'd7 - {z_in1, z_in2, z_in3}];

  truth_table_probe u_main (
    .clk(clk), .rst(rst), .start(start_m), .dut_out(dut_out_m), .expect_id(expect_id),
    .in1(m_in1), .in2(m_in2), .in3(m_in3), .busy(busy_m), .done(done_m),
    .table_id(table_m), .match(match_m), .glitch(glitch_m)
  );

  truth_table_probe #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start_s), .dut_out(dut_out_a), .expect_id(expect_id),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(busy_a), .done(done_a),
    .table_id(table_a), .match(match_a), .glitch(glitch_a)
  );

  truth_table_probe #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start_s), .dut_out(dut_out_z), .expect_id(expect_id),
    .in1(z_in1), .in2(z_in2), .in3(z_in3), .busy(busy_z), .done(done_z),
    .table_id(table_z), .match(match_z), .glitch(glitch_z)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One characterization run. j counts edges after the accepting edge;
  // with period P = SETTLE+1 the vector is j/P, busy while j < 8P,
  // done exactly at j = 8P+1. hold keeps start high for two back-to-back runs.
  task automatic do_run(input logic [7:0] tbl, input logic [7:0] eid,
                        input bit noise, input bit inject, input bit hold);
    logic [7:0] cap_m;
    int last;
    int r;
    cap_m     = tbl ^ (inject ? 8'h10 : 8'h00);
    cut_tbl   = tbl;
    expect_id = eid;
    flip      = 1'b0;
    @(negedge clk);
    start_m = 1'b1;
    start_s = !hold;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    if (!hold) start_m = 1'b0;
    last = hold ? 86 : 45;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      r = (hold && j >= 42) ? j - 42 : j;
      check_val("vec", {29'd0, m_in1, m_in2, m_in3}, (r < 40) ? r / 5 : 0);
      check_val("busy", busy_m, r < 40);
      check_val("done", done_m, r == 41);
      if (r == 41) begin
        ref_id_m    = cap_m;
        ref_match_m = (cap_m == eid);
        check_val("table_id", table_m, ref_id_m);
        check_val("match", match_m, ref_match_m);
        check_val("glitch", glitch_m, C_GLITCH_EN && inject);
      end else begin
        check_val("table_hold", table_m, ref_id_m);
        check_val("match_hold", match_m, ref_match_m);
      end
      if (!hold) begin
        check_val("s1_busy", busy_a, j < 16);
        check_val("s1_done", done_a, j == 17);
        check_val("s0_busy", busy_z, j < 16);
        check_val("s0_done", done_z, j == 17);
        if (j == 17) begin
          ref_id_s    = tbl;
          ref_match_s = (tbl == eid);
          check_val("s1_table", table_a, ref_id_s);
          check_val("s0_table", table_z, ref_id_s);
          check_val("s1_match", match_a, ref_match_s);
          check_val("s0_match", match_z, ref_match_s);
        end
      end else begin
        check_val("s1_idle_done", done_a, 1'b0);
      end
      flip = inject && (j == 19);
      if (hold && j == 82) start_m = 1'b0;
      if (noise && !hold) start_m = (j <= 40) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  initial begin
    logic [7:0] t, e;
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0; flip = 1'b0;
    cut_tbl = 8'h00; expect_id = 8'h00;
    ref_id_m = 8'h00; ref_match_m = 1'b0; ref_id_s = 8'h00; ref_match_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vec", {29'd0, m_in1, m_in2, m_in3}, 0);
    check_val("rst_busy", busy_m, 0);
    check_val("rst_done", done_m, 0);
    check_val("rst_table", table_m, 0);
    check_val("rst_match", match_m, 0);
    check_val("rst_glitch", glitch_m, 0);
    @(negedge clk);
    rst = 1'b0;

    do_run(8'hA7, 8'hA7, 1'b0, 1'b0, 1'b0);
    do_run(8'h01, 8'hA7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      t = 8'($urandom);
      e = ($urandom_range(0, 1) == 1) ? t : 8'($urandom);
      do_run(t, e, 1'b1, 1'b0, 1'b0);
    end
    do_run(8'hA7, 8'hA7, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a run.
    cut_tbl = 8'h3C; expect_id = 8'h3C;
    @(negedge clk);
    start_m = 1'b1; start_s = 1'b1;
    @(posedge clk);
    #1;
    start_m = 1'b0; start_s = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    ref_id_m = 8'h00; ref_match_m = 1'b0; ref_id_s = 8'h00; ref_match_s = 1'b0;
    check_val("mid_rst_vec", {29'd0, m_in1, m_in2, m_in3}, 0);
    check_val("mid_rst_busy", busy_m, 0);
    check_val("mid_rst_done", done_m, 0);
    check_val("mid_rst_table", table_m, 0);
    check_val("mid_rst_match", match_m, 0);
    check_val("mid_rst_glitch", glitch_m, 0);
    check_val("mid_rst_s1_table", table_a, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(posedge clk);
      #1;
      check_val("post_rst_done", done_m, 0);
      check_val("post_rst_busy", busy_m, 0);
    end
    do_run(8'h5C, 8'h5C, 1'b0, 1'b0, 1'b0);

    t = 8'($urandom);
    do_run(t, t, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
